ets_ps_ctrl: RTL
================

ETS_PS_CTRL -- requirements
Module: ets_ps_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_STEPS, default 448, meaning fine-phase steps per shifting_clk period (56 steps per VCO period x 8).
REQ-002 SHALL have parameter POS_W, default 16, meaning width of phase position and target.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ps_clk cycles to wait for ps_done.
REQ-004 SHALL use a single clock ps_clk; reset free_run_rst is synchronous and active-high.
REQ-005 ps_clk  in  1  sole clock; also clocks the MMCM phase-shift port.
REQ-006 free_run_rst  in  1  synchronous active-high reset.
REQ-007 locked  in  1  MMCM lock status.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  command can be accepted.
REQ-010 cmd_target  in  POS_W  absolute phase target in steps.
REQ-011 clear_err  in  1  clears sticky errors and leaves FAULT.
REQ-012 ps_en  out  1  one-cycle phase-step request to the MMCM.
REQ-013 ps_incdec  out  1  step direction: 1 = increment, 0 = decrement.
REQ-014 ps_done  in  1  MMCM step-complete pulse.
REQ-015 cur_pos  out  POS_W  current phase position, 0..PERIOD_STEPS-1.
REQ-016 busy  out  1  asserted when not in IDLE.
REQ-017 done_pulse  out  1  one-cycle pulse when a command completes.
REQ-018 err_timeout, err_unlock, err_range  out  1 each  sticky error flags.

Function
REQ-019 cmd_ready SHALL equal (state==IDLE && locked && no sticky error); a command is accepted on cmd_valid&&cmd_ready.
REQ-020 On accept, the block SHALL compute diff = (cmd_target - cur_pos) mod PERIOD_STEPS; if diff <= PERIOD_STEPS/2, it SHALL make diff increments, otherwise PERIOD_STEPS-diff decrements (a tie is resolved as increment).
REQ-021 If diff==0, the block SHALL go to COMPLETE with no ps_en issued, and done_pulse SHALL assert in the cycle after accept.
REQ-022 If cmd_target >= PERIOD_STEPS, the command SHALL be consumed, err_range SHALL be set, no step SHALL be issued, and the block SHALL return to IDLE.
REQ-023 The state machine states SHALL be IDLE, ISSUE, WAIT_DONE, COMPLETE and FAULT.
  - IDLE -> ISSUE on accept when steps > 0.
  - ISSUE -> WAIT_DONE after one cycle.
  - WAIT_DONE -> ISSUE or COMPLETE on ps_done.
  - COMPLETE -> IDLE after one cycle.
REQ-024 In ISSUE, ps_en SHALL be 1 for exactly one cycle, with ps_incdec valid in the same cycle; at most one step SHALL be outstanding at any time.
REQ-025 On ps_done in WAIT_DONE, cur_pos SHALL change by ±1 with wrap (PERIOD_STEPS-1+1 -> 0, 0-1 -> PERIOD_STEPS-1) and the remaining count SHALL decrement; when the count reaches 0 the block SHALL go to COMPLETE, otherwise to ISSUE.
REQ-026 The wait counter SHALL reset on entry to WAIT_DONE; when it reaches TIMEOUT with no ps_done, the block SHALL set err_timeout and go to FAULT; if ps_done arrives in the same cycle as the timeout, ps_done SHALL win.
REQ-027 ps_done outside WAIT_DONE SHALL be ignored.
REQ-028 locked==0 while busy SHALL set err_unlock and send the block to FAULT, aborting the sweep, except in FAULT itself, where err_unlock is not re-raised.
REQ-029 cur_pos SHALL be forced to 0 whenever locked==0, because the MMCM relocks at zero offset.
REQ-030 FAULT SHALL hold until clear_err; clear_err SHALL clear all sticky flags and return the block to IDLE.
REQ-031 clear_err in IDLE SHALL clear err_range.
REQ-032 The internal remaining-step count SHALL be POS_W bits, and the intermediate difference SHALL be POS_W+1 bits signed to avoid overflow.

Reset
REQ-033 Under free_run_rst, state SHALL go to IDLE, and ps_en, ps_incdec, done_pulse, busy and all error flags SHALL be 0.
REQ-034 Under free_run_rst, cur_pos and the counters SHALL be 0; cmd_ready SHALL then follow REQ-019.
REQ-035 Reset mid-sweep SHALL abandon the sweep without issuing a further ps_en.

Structure
REQ-036 Package ets_ps_pkg SHALL hold the state enum, POS_W, PERIOD_STEPS and TIMEOUT defaults.
REQ-037 The shortest-path direction/count calculation SHALL be a sub-module, ets_ps_path (combinational, registered at accept).

Verification
REQ-038 locked=1, cur_pos=0, target=5, ps_done 3 cycles after each ps_en -> 5 ps_en pulses with incdec=1, cur_pos=5, one done_pulse.
REQ-039 cur_pos=5, target=440 -> 13 decrements with cur_pos wrapping 0 -> 447 and ending at 440.
REQ-040 cur_pos=0, target=224 -> 224 increments (tie); target=5 from 5 -> done_pulse one cycle after accept, zero ps_en.
REQ-041 ps_done withheld -> err_timeout=1 after 255 wait cycles, cmd_ready=0; clear_err -> IDLE, cmd_ready=1.
REQ-042 locked dropped after step 3 of 10 -> FAULT, err_unlock=1, cur_pos=0, no further ps_en.
REQ-043 target=500 -> err_range=1, no ps_en, state IDLE.

Source files
------------

// File: rtl/ets_ps_pkg.sv
// Shared defaults and controller state encoding for the MMCM fine-phase-shift controller.
package ets_ps_pkg;
  localparam int DEF_PERIOD_STEPS = 448;
  localparam int DEF_POS_W        = 16;
  localparam int DEF_TIMEOUT      = 255;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    COMPLETE,
    FAULT
  } ps_state_t;
endpackage

// File: rtl/ets_ps_path.sv
// Shortest-path phase move: direction and step count from the current position to an absolute target.
module ets_ps_path
  import ets_ps_pkg::*;
#(
  parameter int PERIOD_STEPS = DEF_PERIOD_STEPS,
  parameter int POS_W        = DEF_POS_W
) (
  input  logic [POS_W-1:0] cur_pos,
  input  logic [POS_W-1:0] target,
  output logic             incdec,
  output logic [POS_W-1:0] steps,
  output logic             range_err
);
  localparam logic signed [POS_W:0] PERIOD_S = PERIOD_STEPS[POS_W:0];
  localparam logic signed [POS_W:0] HALF_S   = PERIOD_S >>> 1;

  logic signed [POS_W:0] diff_raw;
  logic signed [POS_W:0] diff_mod;
  logic signed [POS_W:0] diff_back;

  assign diff_raw  = $signed({1'b0, target}) - $signed({1'b0, cur_pos});
  assign diff_mod  = diff_raw[POS_W] ? diff_raw + PERIOD_S : diff_raw;
  assign diff_back = PERIOD_S - diff_mod;

  // a half-period tie goes forward
  assign incdec    = (diff_mod <= HALF_S);
  assign steps     = incdec ? POS_W'(diff_mod) : POS_W'(diff_back);
  assign range_err = ($signed({1'b0, target}) >= PERIOD_S);
endmodule

// File: rtl/ets_ps_ctrl.sv
// Steps the MMCM dynamic phase shifter one fine step at a time to an absolute target,
// tracking position with wrap and latching timeout/unlock/range errors.
module ets_ps_ctrl
  import ets_ps_pkg::*;
#(
  parameter int PERIOD_STEPS = DEF_PERIOD_STEPS,
  parameter int POS_W        = DEF_POS_W,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic             ps_clk,
  input  logic             free_run_rst,
  input  logic             locked,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  input  logic             clear_err,
  output logic             ps_en,
  output logic             ps_incdec,
  input  logic             ps_done,
  output logic [POS_W-1:0] cur_pos,
  output logic             busy,
  output logic             done_pulse,
  output logic             err_timeout,
  output logic             err_unlock,
  output logic             err_range
);
  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(PERIOD_STEPS - 1);

  ps_state_t        state, state_nx;
  logic [POS_W-1:0] remaining;
  logic             dir;
  logic [CNT_W-1:0] wait_cnt;

  logic             p_incdec, p_range;
  logic [POS_W-1:0] p_steps;

  logic accept, load, take, clr, set_rng, set_to, set_unl;

  ets_ps_path #(
    .PERIOD_STEPS (PERIOD_STEPS),
    .POS_W        (POS_W)
  ) u_path (
    .cur_pos   (cur_pos),
    .target    (cmd_target),
    .incdec    (p_incdec),
    .steps     (p_steps),
    .range_err (p_range)
  );

  assign cmd_ready  = (state == IDLE) && locked && !(err_timeout || err_unlock || err_range);
  assign accept     = cmd_valid && cmd_ready;
  assign ps_en      = (state == ISSUE);
  assign ps_incdec  = dir;
  assign busy       = (state != IDLE);
  assign done_pulse = (state == COMPLETE);

  always_ff @(posedge ps_clk) begin
    if (free_run_rst) state <= IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    take     = 1'b0;
    clr      = 1'b0;
    set_rng  = 1'b0;
    set_to   = 1'b0;
    set_unl  = 1'b0;
    case (state)
      IDLE: begin
        clr = clear_err;
        if (accept) begin
          if (p_range) begin
            set_rng = 1'b1;
          end else if (p_steps == '0) begin
            state_nx = COMPLETE;
          end else begin
            load     = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!locked) begin
          set_unl  = 1'b1;
          state_nx = FAULT;
        end else begin
          state_nx = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // a step completing in the timeout cycle still counts
        if (!locked) begin
          set_unl  = 1'b1;
          state_nx = FAULT;
        end else if (ps_done) begin
          take     = 1'b1;
          state_nx = (remaining == POS_W'(1)) ? COMPLETE : ISSUE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_to   = 1'b1;
          state_nx = FAULT;
        end
      end
      COMPLETE: begin
        if (!locked) begin
          set_unl  = 1'b1;
          state_nx = FAULT;
        end else begin
          state_nx = IDLE;
        end
      end
      FAULT: begin
        if (clear_err) begin
          clr      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ps_clk) begin
    if (free_run_rst) begin
      cur_pos     <= '0;
      remaining   <= '0;
      dir         <= 1'b0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      err_unlock  <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (load) begin
        remaining <= p_steps;
        dir       <= p_incdec;
      end else if (take) begin
        remaining <= remaining - 1'b1;
      end

      if (state == ISSUE)          wait_cnt <= '0;
      else if (state == WAIT_DONE) wait_cnt <= wait_cnt + 1'b1;

      // the MMCM relocks at zero offset, so an unlocked position is zero
      if (!locked) begin
        cur_pos <= '0;
      end else if (take) begin
        if (dir) cur_pos <= (cur_pos == POS_MAX) ? '0 : cur_pos + 1'b1;
        else     cur_pos <= (cur_pos == '0) ? POS_MAX : cur_pos - 1'b1;
      end

      if (clr) begin
        err_timeout <= 1'b0;
        err_unlock  <= 1'b0;
        err_range   <= 1'b0;
      end
      if (set_to)  err_timeout <= 1'b1;
      if (set_unl) err_unlock  <= 1'b1;
      if (set_rng) err_range   <= 1'b1;
    end
  end
endmodule
